// File: rtl/serial_xmtr.sv
// serial_xmtr: byte-wide host side, 16-bit framed serial line out.
// One-deep holding register feeds a header+body shifter.
module serial_xmtr #(
    parameter logic [7:0]  HEADER     = 8'hA5,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       writing,
    output logic       empty,
    output logic       overrun,
    output logic       sending,
    output logic       data_out
);

    localparam logic       USE_GAP  = (GAP_CYCLES != 0);
    localparam logic [3:0] GAP_LAST = USE_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] hold_q, shift_q;
    logic       empty_d, overrun_d, sending_d, data_d;
    logic       xfer, accept;

    // Body order is bits 6..0 then 7, matching the receiver's reassembly.
    function automatic logic body_bit(input logic [7:0] b, input logic [2:0] c);
        body_bit = (c == 3'd7) ? b[7] : b[3'd6 - c];
    endfunction

    // Control and output registers; the line value is registered with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            gap_q    <= 4'd0;
            empty    <= 1'b1;
            overrun  <= 1'b0;
            sending  <= 1'b0;
            data_out <= IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            empty    <= empty_d;
            overrun  <= overrun_d;
            sending  <= sending_d;
            data_out <= data_d;
        end
    end

    // Byte storage carries no reset; validity is tracked by empty.
    always_ff @(posedge clock) begin
        if (accept) hold_q  <= data_in;
        if (xfer)   shift_q <= hold_q;
    end

    // Next state plus the line value that will appear after this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        xfer      = 1'b0;
        data_d    = IDLE_LEVEL;
        sending_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    xfer      = 1'b1;
                    state_d   = S_HEAD;
                    cnt_d     = 3'd0;
                    data_d    = HEADER[0];
                    sending_d = 1'b1;
                end
            end
            S_HEAD: begin
                sending_d = 1'b1;
                if (cnt_q == 3'd7) begin
                    state_d = S_BODY;
                    cnt_d   = 3'd0;
                    data_d  = body_bit(shift_q, 3'd0);
                end else begin
                    cnt_d  = cnt_q + 3'd1;
                    data_d = HEADER[cnt_d];
                end
            end
            S_BODY: begin
                if (cnt_q != 3'd7) begin
                    cnt_d     = cnt_q + 3'd1;
                    sending_d = 1'b1;
                    data_d    = body_bit(shift_q, cnt_d);
                end else if (USE_GAP) begin
                    state_d = S_GAP;
                    cnt_d   = 3'd0;
                    gap_d   = 4'd0;
                end else if (!empty) begin
                    xfer      = 1'b1;
                    state_d   = S_HEAD;
                    cnt_d     = 3'd0;
                    data_d    = HEADER[0];
                    sending_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else gap_d = gap_q + 4'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // A write lands if holding is free now or is being emptied this edge.
    always_comb begin
        accept    = writing && (empty || xfer);
        empty_d   = empty;
        overrun_d = overrun;
        if (xfer)    empty_d   = 1'b1;
        if (accept)  empty_d   = 1'b0;
        if (writing) overrun_d = !accept;
    end

endmodule

// File: tb/tb_serial_xmtr.sv
// tb_serial_xmtr: two transmitters (no gap, 2-cycle gap) against a
// frame-level model, a loopback deserialiser and directed literals.
module tb_serial_xmtr;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam logic       IDLV = 1'b0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       dout0, send0, empty0, ovr0;
    logic       dout1, send1, empty1, ovr1;

    int nchk = 0;
    int nerr = 0;

    serial_xmtr #(.HEADER(HDR), .IDLE_LEVEL(IDLV), .GAP_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .data_in(d0), .writing(wr0),
        .empty(empty0), .overrun(ovr0), .sending(send0), .data_out(dout0)
    );

    serial_xmtr #(.HEADER(HDR), .IDLE_LEVEL(IDLV), .GAP_CYCLES(2)) dut1 (
        .clock(clock), .reset(reset), .data_in(d1), .writing(wr1),
        .empty(empty1), .overrun(ovr1), .sending(send1), .data_out(dout1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Frame-level model: a scheduled list of future line values per instance.
    logic       lbits [2][32];
    logic       lsend [2][32];
    int         llen  [2] = '{0, 0};
    int         lpos  [2] = '{0, 0};
    logic [7:0] lbyte [2];
    logic       mpend [2] = '{1'b0, 1'b0};
    logic [7:0] mhold [2];
    logic       movr  [2] = '{1'b0, 1'b0};
    logic       eout  [2] = '{IDLV, IDLV};
    logic       esend [2] = '{1'b0, 1'b0};
    logic [7:0] mx    [2][16];
    int         nmx   [2] = '{0, 0};

    task automatic mreset(input int k);
        lpos[k] = 0; llen[k] = 0; mpend[k] = 1'b0;
        movr[k] = 1'b0; eout[k] = IDLV; esend[k] = 1'b0;
    endtask

    task automatic build(input int k, input logic [7:0] b, input int g);
        for (int i = 0; i < 8; i++) lbits[k][i] = HDR[i];
        for (int j = 0; j < 7; j++) lbits[k][8 + j] = b[6 - j];
        lbits[k][15] = b[7];
        for (int i = 0; i < 16; i++) lsend[k][i] = 1'b1;
        llen[k] = 16 + g + ((g > 0) ? 1 : 0);
        for (int i = 16; i < llen[k]; i++) begin
            lbits[k][i] = IDLV;
            lsend[k][i] = 1'b0;
        end
        lbyte[k] = b;
        lpos[k]  = 0;
    endtask

    task automatic mstep(input int k, input logic wr, input logic [7:0] din,
                         input int g);
        logic xf, acc;
        xf = 1'b0;
        if (lpos[k] >= llen[k] && mpend[k]) begin
            xf = 1'b1;
            build(k, mhold[k], g);
        end
        acc = wr && (!mpend[k] || xf);
        if (xf) mpend[k] = 1'b0;
        if (acc) begin
            mhold[k] = din;
            mpend[k] = 1'b1;
            movr[k]  = 1'b0;
        end else if (wr) begin
            movr[k] = 1'b1;
        end
        if (lpos[k] < llen[k]) begin
            eout[k]  = lbits[k][lpos[k]];
            esend[k] = lsend[k][lpos[k]];
            if (lpos[k] == 15 && nmx[k] < 16) begin
                mx[k][nmx[k]] = lbyte[k];
                nmx[k]++;
            end
            lpos[k]++;
        end else begin
            eout[k]  = IDLV;
            esend[k] = 1'b0;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, wr0, d0, 0);
            mstep(1, wr1, d1, 2);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (!reset) begin
            chk("dut0 data_out", dout0, eout[0]);
            chk("dut0 sending", send0, esend[0]);
            chk("dut0 empty", empty0, !mpend[0]);
            chk("dut0 overrun", ovr0, movr[0]);
            chk("dut1 data_out", dout1, eout[1]);
            chk("dut1 sending", send1, esend[1]);
            chk("dut1 empty", empty1, !mpend[1]);
            chk("dut1 overrun", ovr1, movr[1]);
        end
    end

    // Loopback deserialiser: 16 sending bits make one frame.
    logic [15:0] rb  [2];
    int          rc  [2] = '{0, 0};
    logic [7:0]  rx  [2][16];
    int          nrx [2] = '{0, 0};

    task automatic rxbit(input int k, input logic s, input logic d);
        logic [7:0] hx;
        if (s) begin
            rb[k] = {rb[k][14:0], d};
            rc[k]++;
            if (rc[k] == 16) begin
                rc[k] = 0;
                for (int i = 0; i < 8; i++) hx[7 - i] = HDR[i];
                chk($sformatf("rx%0d header", k), rb[k][15:8], hx);
                if (nrx[k] < 16) begin
                    rx[k][nrx[k]] = {rb[k][0], rb[k][7:1]};
                    nrx[k]++;
                end
            end
        end
    endtask

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            rc[0] = 0;
            rc[1] = 0;
        end else begin
            rxbit(0, send0, dout0);
            rxbit(1, send1, dout1);
        end
    end

    // Line history and run lengths for the directed checks.
    logic [63:0] rec0 = '0;
    int run0 = 0;
    int low1 = 0;
    int gap1 = 0;

    always @(negedge clock) begin
        rec0 = {rec0[62:0], dout0};
        run0 = send0 ? run0 + 1 : 0;
        if (send1) begin
            if (low1 > 0) gap1 = low1;
            low1 = 0;
        end else begin
            low1++;
        end
    end

    task automatic pulse0(input logic [7:0] b);
        wr0 = 1'b1; d0 = b;
        @(negedge clock);
        wr0 = 1'b0;
    endtask

    task automatic pulse1(input logic [7:0] b);
        wr1 = 1'b1; d1 = b;
        @(negedge clock);
        wr1 = 1'b0;
    endtask

    task automatic wait_empty(input int k);
        int n;
        n = 0;
        while (((k == 0) ? empty0 : empty1) == 1'b0 && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (n >= 64) chk($sformatf("wait empty%0d timeout", k), 0, 1);
    endtask

    logic [15:0] bits1;
    int          sc;
    logic [7:0]  exp0 [8] = '{8'h3C, 8'h81, 8'h7E, 8'h55,
                              8'h66, 8'h12, 8'h34, 8'h5A};
    logic [7:0]  exp1 [2] = '{8'hE7, 8'h18};

    initial begin
        @(negedge clock);
        chk("reset data_out", dout0, IDLV);
        chk("reset sending", send0, 0);
        chk("reset empty", empty0, 1);
        chk("reset overrun", ovr0, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single byte frame.
        pulse0(8'h3C);
        chk("t1 empty low", empty0, 0);
        sc = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            bits1[15 - i] = dout0;
            if (send0) sc++;
            if (i == 0) chk("t1 empty back", empty0, 1);
        end
        chk("t1 frame bits", bits1, 16'hA578);
        chk("t1 sending cycles", sc, 16);
        @(negedge clock);
        chk("t1 idle level", dout0, IDLV);
        chk("t1 sending off", send0, 0);
        repeat (3) @(negedge clock);

        // Back-to-back frames.
        pulse0(8'h81);
        wait_empty(0);
        pulse0(8'h7E);
        repeat (30) @(negedge clock);
        #1;
        chk("t2 two frames", rec0[31:0], 32'hA503A5FC);
        chk("t2 contiguous", run0, 32);
        chk("t2 overrun", ovr0, 0);
        repeat (5) @(negedge clock);

        // Overrun while full and busy.
        pulse0(8'h55);
        wait_empty(0);
        pulse0(8'h66);
        pulse0(8'hFF);
        chk("t3 overrun set", ovr0, 1);
        chk("t3 still full", empty0, 0);
        wait_empty(0);
        pulse0(8'h12);
        chk("t3 overrun cleared", ovr0, 0);

        // Write on the back-to-back transfer edge.
        repeat (14) @(negedge clock);
        chk("t4 full before", empty0, 0);
        pulse0(8'h34);
        chk("t4 no overrun", ovr0, 0);
        chk("t4 stays full", empty0, 0);
        repeat (40) @(negedge clock);

        // Asynchronous reset mid-body with a byte pending.
        pulse0(8'h9A);
        wait_empty(0);
        pulse0(8'hC3);
        repeat (10) @(negedge clock);
        chk("t5 mid-frame sending", send0, 1);
        chk("t5 body bit3", dout0, 1);
        #1 reset = 1'b1;
        #1;
        chk("t5 async data_out", dout0, IDLV);
        chk("t5 async sending", send0, 0);
        chk("t5 async empty", empty0, 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        pulse0(8'h5A);
        repeat (20) @(negedge clock);

        // Two-cycle gap instance.
        pulse1(8'hE7);
        wait_empty(1);
        pulse1(8'h18);
        repeat (40) @(negedge clock);
        #1;
        chk("t6 idle bits between", gap1, 3);
        chk("t6 overrun", ovr1, 0);

        // Loopback byte order against literals and the model.
        chk("rx0 count", nrx[0], 8);
        chk("model0 count", nmx[0], 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rx0 byte %0d", i), rx[0][i], exp0[i]);
            chk($sformatf("model0 byte %0d", i), mx[0][i], exp0[i]);
        end
        chk("rx1 count", nrx[1], 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rx1 byte %0d", i), rx[1][i], exp1[i]);
            chk($sformatf("model1 byte %0d", i), mx[1][i], exp1[i]);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
